stack_control: RTL and testbench
================================

STACK_CONTROL -- requirements
Module: stack_control

Interface
REQ-001 SHALL have parameter DELAY_BASE, default 24'd5_000_000: WAIT-state length, in clk cycles, at level 0.
REQ-002 SHALL have parameter DELAY_STEP, default 24'd150_000: cycles removed from the WAIT length per level.
REQ-003 SHALL have parameter DELAY_MIN, default 24'd500_000: floor on the WAIT length.
REQ-004 SHALL have parameter MAX_LEVEL, default 6'd30: level at which the game ends (top row, y = 0).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 go  in  1  place/start request; synchronous single-cycle pulse, already debounced.
REQ-008 done_load  in  1  position-update-complete flag from the coordinate loader.
REQ-009 ld_x  out  1  request a horizontal step from the coordinate loader.
REQ-010 ld_y  out  1  request a row (y) update from the coordinate loader.
REQ-011 colour_erase_enable  out  1  forces the drawn colour to black.
REQ-012 plot  out  1  VGA write enable.
REQ-013 x_offset  out  2  pixel column within the 4x4 block.
REQ-014 y_offset  out  2  pixel row within the 4x4 block.
REQ-015 curr_level  out  6  number of rows placed so far.
REQ-016 game_over  out  1  high while in state OVER.

Function
REQ-017 SHALL implement states IDLE, LOAD, DRAW, WAIT, ERASE, PLACE, OVER.
REQ-018 IDLE: all strobes low; go -> LOAD on the next edge; curr_level held at 0.
REQ-019 LOAD: ld_x = ld_y = 1; stays in LOAD while done_load = 0; done_load = 1 -> DRAW.
REQ-020 DRAW: plot = 1 for exactly 16 cycles.
REQ-021 In DRAW, offsets SHALL sweep {y_offset, x_offset} from 0 to 15, x_offset fastest (row-major).
REQ-022 DRAW: after the cycle with offset 15, offsets wrap to 0 and state -> WAIT.
REQ-023 WAIT: plot = 0; a 24-bit down-counter loads L = max(DELAY_BASE - curr_level*DELAY_STEP, DELAY_MIN), computed at 24 bits with no underflow.
REQ-024 WAIT SHALL last exactly L cycles; then -> PLACE if go_pending, else -> ERASE.
REQ-025 ERASE: plot = 1 and colour_erase_enable = 1 for 16 cycles with the same offset sweep; then -> LOAD.
REQ-026 go_pending SHALL set on go in any of LOAD, DRAW, WAIT, ERASE.
REQ-027 go_pending SHALL clear on entry to PLACE.
REQ-028 go in IDLE starts the game and does not set go_pending.
REQ-029 A go arriving during ERASE is honoured at the end of the following WAIT.
REQ-030 PLACE (1 cycle): the block stays drawn (no erase); curr_level increments by 1.
REQ-031 PLACE exit: if the new curr_level == MAX_LEVEL -> OVER, else -> LOAD.
REQ-032 OVER: game_over = 1; all strobes low; go ignored; only resetn exits.
REQ-033 Multiple go pulses before PLACE SHALL count as one placement.
REQ-034 curr_level SHALL never exceed MAX_LEVEL and SHALL never wrap.
REQ-035 colour_erase_enable SHALL be high only in ERASE.
REQ-036 plot SHALL be high only in DRAW and ERASE.
REQ-037 ld_x and ld_y SHALL be high only in LOAD.

Reset
REQ-038 resetn low SHALL, asynchronously, force: state = IDLE, curr_level = 0, go_pending = 0, counters = 0, all outputs = 0.
REQ-039 Reset asserted mid-DRAW or mid-ERASE SHALL abort the sweep immediately; no plot pulse occurs after reset asserts.
REQ-040 After resetn deasserts, the block SHALL remain in IDLE until go.

Verification (params DELAY_BASE=40, DELAY_STEP=2, DELAY_MIN=8, MAX_LEVEL=3)
REQ-041 Start: reset, go pulse, done_load tied 1 -> LOAD 1 cycle; DRAW 16 plot cycles with offsets 0..15; WAIT 40 cycles; ERASE 16 cycles with colour_erase_enable = 1; LOAD again.
REQ-042 Place: go mid-DRAW at level 0 -> after WAIT (40 cycles) no ERASE; PLACE; curr_level = 1; next WAIT lasts 38 cycles.
REQ-043 Handshake: done_load held 0 for 5 cycles in LOAD -> ld_x/ld_y high 5+1 cycles; no plot until done_load = 1.
REQ-044 Floor and game over: DELAY_STEP=20 at level 2 -> WAIT = 8 cycles (floor); third placement -> curr_level = 3, game_over = 1; later go pulses cause no change.
REQ-045 Reset: resetn pulsed low at DRAW offset 7 -> plot drops in the same cycle; all outputs 0; state IDLE; curr_level = 0.
REQ-046 Double go: 3 go pulses within one WAIT -> exactly one increment of curr_level.

Source files
------------

// File: rtl/stack_control.sv
// rtl/stack_control.sv - block-stacking game sequencer: load, draw, wait, erase, place, game over
//
// Ports:
//   clk                  sole clock, rising edge
//   resetn               asynchronous active-low reset
//   go                   place/start pulse (single cycle, debounced)
//   done_load            coordinate loader finished its position update
//   ld_x, ld_y           step / row-update requests to the coordinate loader (LOAD only)
//   colour_erase_enable  force drawn colour to black (ERASE only)
//   plot                 VGA write enable (DRAW and ERASE)
//   x_offset, y_offset   pixel position inside the 4x4 block, row-major sweep
//   curr_level           rows placed so far
//   game_over            high while in OVER
module stack_control #(
    parameter logic [23:0] DELAY_BASE = 24'd5_000_000,
    parameter logic [23:0] DELAY_STEP = 24'd150_000,
    parameter logic [23:0] DELAY_MIN  = 24'd500_000,
    parameter logic [5:0]  MAX_LEVEL  = 6'd30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       done_load,
    output logic       ld_x,
    output logic       ld_y,
    output logic       colour_erase_enable,
    output logic       plot,
    output logic [1:0] x_offset,
    output logic [1:0] y_offset,
    output logic [5:0] curr_level,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAW, S_WAIT, S_ERASE, S_PLACE, S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sweep_q, sweep_d;
    logic [23:0] wait_q, wait_d;
    logic [5:0]  level_q, level_d;
    logic        pend_q, pend_d;
    logic        ld_q, ld_d;
    logic        erase_q, erase_d;
    logic        plot_q, plot_d;
    logic        over_q, over_d;

    // WAIT length: base minus per-level reduction, floored at DELAY_MIN.
    // The product is formed at 30 bits so a large level*step can never wrap
    // back into a small positive difference.
    logic [29:0] step_total;
    logic [23:0] diff;
    logic [23:0] wait_len;

    assign step_total = 30'(level_q) * 30'(DELAY_STEP);

    always_comb begin
        diff     = '0;
        wait_len = DELAY_MIN;
        if (step_total < {6'd0, DELAY_BASE}) begin
            diff = DELAY_BASE - step_total[23:0];
            if (diff >= DELAY_MIN) begin
                wait_len = diff;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        wait_d  = wait_q;
        level_d = level_q;
        pend_d  = pend_q;

        // A go while the block is in flight arms one placement; repeats merge.
        if (go && (state_q == S_LOAD || state_q == S_DRAW ||
                   state_q == S_WAIT || state_q == S_ERASE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (go) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (done_load) begin
                    state_d = S_DRAW;
                    sweep_d = 4'd0;
                end
            end
            S_DRAW: begin
                sweep_d = sweep_q + 4'd1;
                if (sweep_q == 4'd15) begin
                    state_d = S_WAIT;
                    wait_d  = (wait_len == 24'd0) ? 24'd0 : wait_len - 24'd1;
                end
            end
            S_WAIT: begin
                if (wait_q == 24'd0) begin
                    if (pend_q) begin
                        state_d = S_PLACE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_ERASE;
                        sweep_d = 4'd0;
                    end
                end else begin
                    wait_d = wait_q - 24'd1;
                end
            end
            S_ERASE: begin
                sweep_d = sweep_q + 4'd1;
                if (sweep_q == 4'd15) state_d = S_LOAD;
            end
            S_PLACE: begin
                if (level_q < MAX_LEVEL) level_d = level_q + 6'd1;
                if (level_d >= MAX_LEVEL) state_d = S_OVER;
                else                      state_d = S_LOAD;
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with it.
        ld_d    = (state_d == S_LOAD);
        erase_d = (state_d == S_ERASE);
        plot_d  = (state_d == S_DRAW) || (state_d == S_ERASE);
        over_d  = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sweep_q <= '0;
            wait_q  <= '0;
            level_q <= '0;
            pend_q  <= 1'b0;
            ld_q    <= 1'b0;
            erase_q <= 1'b0;
            plot_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            wait_q  <= wait_d;
            level_q <= level_d;
            pend_q  <= pend_d;
            ld_q    <= ld_d;
            erase_q <= erase_d;
            plot_q  <= plot_d;
            over_q  <= over_d;
        end
    end

    // The sweep counter rests at 0 outside DRAW/ERASE, so it drives the offsets directly.
    assign ld_x                = ld_q;
    assign ld_y                = ld_q;
    assign colour_erase_enable = erase_q;
    assign plot                = plot_q;
    assign x_offset            = sweep_q[1:0];
    assign y_offset            = sweep_q[3:2];
    assign curr_level          = level_q;
    assign game_over           = over_q;

endmodule

// File: tb/tb_stack_control.sv
// tb/tb_stack_control.sv - randomized scoreboard bench for stack_control (two parameter sets)
module tb_stack_control;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic go = 1'b0;
    logic done_load = 1'b1;

    logic       ld_x0, ld_y0, ce0, plot0, go0;
    logic [1:0] xo0, yo0;
    logic [5:0] lvl0;
    logic       ld_x1, ld_y1, ce1, plot1, go1;
    logic [1:0] xo1, yo1;
    logic [5:0] lvl1;

    always #5 clk = ~clk;

    stack_control #(.DELAY_BASE(24'd40), .DELAY_STEP(24'd2), .DELAY_MIN(24'd8), .MAX_LEVEL(6'd3)) u0 (
        .clk(clk), .resetn(resetn), .go(go), .done_load(done_load),
        .ld_x(ld_x0), .ld_y(ld_y0), .colour_erase_enable(ce0), .plot(plot0),
        .x_offset(xo0), .y_offset(yo0), .curr_level(lvl0), .game_over(go0)
    );

    stack_control #(.DELAY_BASE(24'd40), .DELAY_STEP(24'd20), .DELAY_MIN(24'd8), .MAX_LEVEL(6'd3)) u1 (
        .clk(clk), .resetn(resetn), .go(go), .done_load(done_load),
        .ld_x(ld_x1), .ld_y(ld_y1), .colour_erase_enable(ce1), .plot(plot1),
        .x_offset(xo1), .y_offset(yo1), .curr_level(lvl1), .game_over(go1)
    );

    wire [14:0] act0 = {go0, ld_x0, ld_y0, ce0, plot0, yo0, xo0, lvl0};
    wire [14:0] act1 = {go1, ld_x1, ld_y1, ce1, plot1, yo1, xo1, lvl1};

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    // Reference model: game phase plus sweep index / remaining wait cycles.
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAW = 2, M_WAIT = 3,
                   M_ERASE = 4, M_PLACE = 5, M_OVER = 6;
    int phase[2];
    int idx[2];
    int rem[2];
    int level[2];
    bit pend[2];

    function automatic int wait_cycles(input int i);
        int v;
        v = 40 - level[i] * ((i == 0) ? 2 : 20);
        return (v < 8) ? 8 : v;
    endfunction

    function automatic logic [14:0] expected(input int i);
        logic sweeping;
        logic [3:0] off;
        logic [5:0] lv;
        sweeping = (phase[i] == M_DRAW) || (phase[i] == M_ERASE);
        off = sweeping ? 4'(idx[i]) : 4'd0;
        lv = 6'(level[i]);
        return {phase[i] == M_OVER, phase[i] == M_LOAD, phase[i] == M_LOAD,
                phase[i] == M_ERASE, sweeping, off, lv};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i] = M_IDLE; idx[i] = 0; rem[i] = 0; level[i] = 0; pend[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit g, input bit dl);
        bit was_pending;
        was_pending = pend[i];
        if (g && phase[i] inside {M_LOAD, M_DRAW, M_WAIT, M_ERASE}) pend[i] = 1'b1;
        case (phase[i])
            M_IDLE: if (g) phase[i] = M_LOAD;
            M_LOAD: if (dl) begin phase[i] = M_DRAW; idx[i] = 0; end
            M_DRAW: begin
                if (idx[i] == 15) begin phase[i] = M_WAIT; idx[i] = 0; rem[i] = wait_cycles(i); end
                else idx[i]++;
            end
            M_WAIT: begin
                if (rem[i] == 1) begin
                    if (was_pending) begin phase[i] = M_PLACE; pend[i] = 1'b0; end
                    else begin phase[i] = M_ERASE; idx[i] = 0; end
                end else rem[i]--;
            end
            M_ERASE: begin
                if (idx[i] == 15) begin phase[i] = M_LOAD; idx[i] = 0; end
                else idx[i]++;
            end
            M_PLACE: begin
                level[i]++;
                phase[i] = (level[i] == 3) ? M_OVER : M_LOAD;
            end
            default: ;
        endcase
    endtask

    logic [14:0] q0[$];
    logic [14:0] q1[$];

    // Monitor: every cycle the DUT presents new outputs, compare against the queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("u0_outputs", act0, q0.pop_front());
            if (q1.size() > 0) check("u1_outputs", act1, q1.pop_front());
        end
    end

    // Stimulus: random go / done_load, periodic resets, one reset mid-DRAW per armed episode.
    initial begin
        int rate;
        bit mid_used;
        bit prev_resetn;
        model_reset();
        prev_resetn = 1'b0;
        for (int ep = 0; ep < 6; ep++) begin
            rate = (ep % 3 == 0) ? 40 : ((ep % 3 == 1) ? 15 : 150);
            mid_used = !(ep == 1 || ep == 4);
            for (int cyc = 0; cyc < 1200; cyc++) begin
                @(negedge clk);
                if (cyc < 2) begin
                    resetn = 1'b0;
                end else if (!mid_used && phase[0] == M_DRAW && idx[0] == 7) begin
                    resetn = 1'b0;
                    mid_used = 1'b1;
                end else begin
                    resetn = 1'b1;
                end
                if (prev_resetn && !resetn) begin
                    #1;
                    check("async_reset_u0", act0, 15'd0);
                    check("async_reset_u1", act1, 15'd0);
                end
                prev_resetn = resetn;
                go = (cyc >= 2) && ($urandom_range(0, rate - 1) == 0);
                done_load = ($urandom_range(0, 3) != 0);
                if (!resetn) begin
                    model_reset();
                end else begin
                    model_step(0, go, done_load);
                    model_step(1, go, done_load);
                end
                q0.push_back(expected(0));
                q1.push_back(expected(1));
            end
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL queue_drain actual=%0d/%0d expected=0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
